sevseg_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver. It latches an N-digit hexadecimal value plus per-digit decimal points and scans them onto a shared segment bus with one digit-enable line per digit. It supersedes the standalone single-digit decoder for board displays: it adds refresh timing, anti-ghosting guard cycles, tear-free frame updates and selectable output polarity.

---
 rtl/sevseg_pkg.sv | 20 ++
 rtl/sevseg_glyph.sv | 11 +
 rtl/sevseg_scan.sv | 144 ++++++++++++++
 tb/tb_sevseg_scan.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and glyph table for the seven-segment scan driver.
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    // Active-high g..a patterns indexed by hex digit value.
    localparam seg_t GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t hex_to_seg(input logic [3:0] d);
        return GLYPHS[d];
    endfunction

endpackage

// File: rtl/sevseg_glyph.sv
// Combinational hex digit to active-high segment decoder.
module sevseg_glyph
    import sevseg_pkg::*;
(
    input  logic [3:0] digit,
    output seg_t       seg
);

    assign seg = hex_to_seg(digit);

endmodule

// File: rtl/sevseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with tear-free frame commit.
// Leading-zero blanking is compiled in when SEVSEG_SCAN_LZB_EN is defined.
module sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // run is low only in the first cycle out of reset, which becomes
    // the digit-0 guard cycle without counting as a frame boundary.
    logic                    run;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic                    wrap;
    logic                    boundary;
    logic                    commit;
    logic [CW-1:0]           cnt_n;
    logic [IW-1:0]           idx_n;
    logic [4*NUM_DIGITS-1:0] disp_val_n;
    logic [NUM_DIGITS-1:0]   disp_dp_n;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              digit;
    logic                    dp_cur;
    logic                    blank_cur;
    seg_t                    glyph;
    seg_t                    seg_n;
    logic [NUM_DIGITS-1:0]   an_on;

    always_comb begin
        wrap  = run && (cnt == CNT_LAST);
        cnt_n = (!run || wrap) ? '0 : cnt + 1'b1;
        if (!run) begin
            idx_n = '0;
        end else if (wrap) begin
            idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            idx_n = idx;
        end
        boundary   = wrap && (idx_n == '0);
        commit     = boundary && pending;
        disp_val_n = commit ? shadow_val : disp_val;
        disp_dp_n  = commit ? shadow_dp : disp_dp;
    end

`ifdef SEVSEG_SCAN_LZB_EN
    logic zero_above;

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (disp_val_n[4*i +: 4] == 4'h0);
            blank[i]   = zero_above;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        digit     = '0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_n == IW'(i)) begin
                digit     = disp_val_n[4*i +: 4];
                dp_cur    = disp_dp_n[i];
                blank_cur = blank[i];
            end
        end
    end

    sevseg_glyph u_glyph (
        .digit (digit),
        .seg   (glyph)
    );

    always_comb begin
        seg_n = blank_cur ? SEG_OFF : glyph;
        an_on = NUM_DIGITS'(1) << idx_n;
        if (cnt_n == '0) begin
            an_on = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run        <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            segments   <= {7{SEG_ACTIVE_LOW}};
            dp         <= SEG_ACTIVE_LOW;
            anodes     <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_done <= 1'b0;
        end else begin
            run      <= 1'b1;
            cnt      <= cnt_n;
            idx      <= idx_n;
            disp_val <= disp_val_n;
            disp_dp  <= disp_dp_n;
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            segments   <= seg_n ^ {7{SEG_ACTIVE_LOW}};
            dp         <= dp_cur ^ SEG_ACTIVE_LOW;
            anodes     <= an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_sevseg_scan.sv
// Scoreboard bench for sevseg_scan: per-cycle expectations queued ahead,
// a negedge monitor pops and compares anodes/segments/dp/frame_done.
module tb_sevseg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int e = 0;
    int mcyc = 0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    sevseg_scan #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .segments   (segments),
        .dp         (dp),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    // Expected active-low digit patterns {d3,d2,d1,d0}
    localparam logic [27:0] S1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] SABCD = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] S2222 = {7'h24, 7'h24, 7'h24, 7'h24};
    localparam logic [27:0] S3333 = {7'h30, 7'h30, 7'h30, 7'h30};
    localparam logic [27:0] S5678 = {7'h12, 7'h02, 7'h78, 7'h00};
`ifdef SEVSEG_SCAN_LZB_EN
    localparam logic [27:0] S0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] S0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
`else
    localparam logic [27:0] S0000 = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] S0050 = {7'h40, 7'h40, 7'h12, 7'h40};
`endif

    task automatic push_reset();
        exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
    endtask

    task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpv,
                              input bit fd_first, input int n);
        logic [3:0] one;
        logic [3:0] an;
        int k;
        one = 4'b0001;
        for (int c = 0; c < n; c++) begin
            k  = c / 4;
            an = (c % 4 == 0) ? 4'hF : ~(one << k);
            exp_q.push_back({an, segs[7*k +: 7], ~dpv[k], fd_first && (c == 0)});
        end
    endtask

    task automatic at_edge(input int k);
        while (e < k) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic do_load(input int k, input logic [15:0] v, input logic [3:0] d);
        at_edge(k - 1);
        value = v;
        dp_in = d;
        load  = 1'b1;
        at_edge(k);
        load  = 1'b0;
    endtask

    initial begin
        logic [12:0] w;
        logic [12:0] g;
        @(posedge clk);
        forever begin
            @(negedge clk);
            mcyc++;
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                g = {anodes, segments, dp, frame_done};
                checks++;
                if (g !== w) begin
                    errors++;
                    $display("FAIL scan cyc%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                             mcyc, g[12:9], g[8:2], g[1], g[0], w[12:9], w[8:2], w[1], w[0]);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish in 20000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        dp_in = '0;
        push_reset();
        push_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e   = 0;

        push_frame(S0000, 4'b0000, 1'b0, 16);
        push_frame(S1234, 4'b0001, 1'b1, 16);
        push_frame(S1234, 4'b0001, 1'b1, 16);
        do_load(5, 16'h1234, 4'b0001);

        push_frame(SABCD, 4'b1000, 1'b1, 16);
        do_load(43, 16'hABCD, 4'b1000);

        push_frame(S2222, 4'b0000, 1'b1, 16);
        do_load(51, 16'h1111, 4'b0000);
        do_load(55, 16'h2222, 4'b0000);

        push_frame(S3333, 4'b0010, 1'b1, 16);
        push_frame(S5678, 4'b0000, 1'b1, 16);
        do_load(70, 16'h3333, 4'b0010);
        do_load(81, 16'h5678, 4'b0000);

        push_frame(S0000, 4'b0000, 1'b1, 16);
        do_load(100, 16'h0000, 4'b0000);

        push_frame(S0050, 4'b0100, 1'b1, 10);
        do_load(116, 16'h0050, 4'b0100);

        push_reset();
        push_frame(S0000, 4'b0000, 1'b0, 16);
        push_frame(S0000, 4'b0000, 1'b1, 16);
        do_load(138, 16'h9999, 4'b1111);
        rst = 1'b1;
        at_edge(139);
        rst = 1'b0;

        at_edge(176);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
